if_prefetch_queue: RTL

- Parametrised instruction-fetch stage for the MIPS pipeline.
- Holds the PC, fetches from a synchronous instruction memory with 1-cycle read latency, and buffers fetched words in a DEPTH-entry queue.
- Presents instr/PC/PC+4/PC+8 to decode under a valid/ready handshake.
- Supports single-cycle redirect (branch/jump/exception) with queue flush and in-flight kill.

---
 rtl/if_prefetch_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: PC register, 1-cycle-latency imem interface and a DEPTH-entry prefetch queue.
// Define IF_ADEL_EN to enable fetch address-error (AdEL) detection, which halts fetch until the next redirect.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic [31:0] out_pc8,
    output logic        out_exc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q;
    logic [31:0]   issue_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic          halt;
    logic          illegal;
    logic          issue_exc;
    logic [31:0]   load_pc;
    logic [CW:0]   occupancy;
    logic          fetch_go;
    logic          enq;
    logic          deq;

    // In-flight fetches reserve a slot so the queue can never overflow.
    assign occupancy = {1'b0, count} + (CW + 1)'(inflight);
    assign fetch_go  = reset && !redirect && !halt && (occupancy < (CW + 1)'(DEPTH));
    assign enq       = inflight && !redirect;
    assign deq       = out_valid && out_ready && !redirect;

`ifdef IF_ADEL_EN
    logic exc_mem [DEPTH];

    assign illegal   = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);
    assign imem_en   = fetch_go && !illegal;
    assign imem_addr = pc_q;
    assign load_pc   = redirect_pc;
    assign out_exc   = out_valid && exc_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt      <= 1'b0;
            issue_exc <= 1'b0;
        end else if (redirect) begin
            halt      <= 1'b0;
            issue_exc <= 1'b0;
        end else begin
            issue_exc <= illegal;
            if (fetch_go && illegal)
                halt <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq)
            exc_mem[wr_ptr] <= issue_exc;
    end
`else
    logic unused_cfg;

    assign illegal    = 1'b0;
    assign halt       = 1'b0;
    assign issue_exc  = 1'b0;
    assign imem_en    = fetch_go;
    assign imem_addr  = {pc_q[31:2], 2'b00};
    assign load_pc    = {redirect_pc[31:2], 2'b00};
    assign out_exc    = 1'b0;
    assign unused_cfg = &{1'b0, redirect_pc[1:0], PC_LO, PC_HI};
`endif

    // Redirect outranks issue, response and dequeue in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            issue_pc <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect) begin
            pc_q     <= load_pc;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= fetch_go;
            issue_pc <= pc_q;
            if (fetch_go && !illegal)
                pc_q <= pc_q + 32'd4;
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    // NOTE: queue storage has no reset; out_valid (count) qualifies every read, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr] <= issue_exc ? 32'h0 : imem_rdata;
            pc_mem[wr_ptr]    <= issue_pc;
        end
    end

    assign out_valid = (count != '0);
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];
    assign out_pc4   = out_pc + 32'd4;
    assign out_pc8   = out_pc + 32'd8;

endmodule
